hex_display_bank: RTL and testbench



---
 rtl/hex_display_pkg.sv | 26 ++
 rtl/hex_display_bank_hex_to_seg7.sv | 14 +
 rtl/hex_display_bank.sv | 126 ++++++++++++
 tb/tb_hex_display_bank.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// Shared constants for the hex 7-segment display bank: digit limit, blank pattern
// and the active-high glyph table (bit order g..a, a = LSB).
package hex_display_pkg;

    localparam int MAX_DIGITS = 8;

    // Active-high domain: polarity is applied only at the output registers.
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Entry n is the glyph for nibble n; entry 0 sits in the low 7 bits.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] polarize(input logic [6:0] seg, input logic active_low);
        logic [6:0] res;
        if (active_low) begin
            res = ~seg;
        end else begin
            res = seg;
        end
        return res;
    endfunction

endpackage

// File: rtl/hex_display_bank_hex_to_seg7.sv
// Combinational nibble to active-high 7-segment glyph lookup.
module hex_to_seg7
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Table lookup of the glyph for this nibble
    always_comb begin
        seg_o = GLYPH_TABLE[nibble_i];
    end

endmodule

// File: rtl/hex_display_bank.sv
// N-digit hex 7-segment driver: latched value, leading-zero blanking, per-digit
// blink, and either static per-digit buses or a time-multiplexed scan bus.
module hex_display_bank
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 25000,
    parameter int BLINK_DIV  = 12500000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    latch,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    input  logic                    mux_mode,
    output logic [7*NUM_DIGITS-1:0] seg_static_out,
    output logic [6:0]              seg_mux_out,
    output logic [NUM_DIGITS-1:0]   digit_sel_out
);

    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic AL    = (ACTIVE_LOW != 0);
    localparam logic [6:0] SEG_OFF = AL ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{AL}};

    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic                    loaded_q, loaded_d;
    logic [SCAN_W-1:0]       scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]        scan_idx_q, scan_idx_d;
    logic [BLINK_W-1:0]      blink_cnt_q, blink_cnt_d;
    logic                    blink_ph_q, blink_ph_d;
    logic [7*NUM_DIGITS-1:0] seg_static_q, seg_static_d;
    logic [6:0]              seg_mux_q, seg_mux_d;
    logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;

    logic [6:0]              glyph_s     [NUM_DIGITS];
    logic [6:0]              digit_seg_s [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   lz_blank_s;
    logic                    scan_wrap_s;
    logic                    blink_wrap_s;

    // Per-digit decode; digit 0 is never leading-zero blanked so zero shows "0"
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        hex_to_seg7 u_dec (
            .nibble_i (value_q[4*k +: 4]),
            .seg_o    (glyph_s[k])
        );
        if (k == 0) begin : g_lsd
            assign lz_blank_s[k] = 1'b0;
        end else begin : g_upper
            assign lz_blank_s[k] = blank_lz & ~(|value_q[4*NUM_DIGITS-1:4*k]);
        end
        assign digit_seg_s[k] = (lz_blank_s[k] | (blink_ph_q & blink_en[k])) ? SEG_BLANK : glyph_s[k];
    end

    // Capture and free-running scan/blink counters
    always_comb begin
        value_d      = latch ? value_in : value_q;
        loaded_d     = loaded_q | latch;
        scan_wrap_s  = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
        blink_wrap_s = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
        scan_cnt_d   = scan_wrap_s ? {SCAN_W{1'b0}} : scan_cnt_q + SCAN_W'(1);
        blink_cnt_d  = blink_wrap_s ? {BLINK_W{1'b0}} : blink_cnt_q + BLINK_W'(1);
        blink_ph_d   = blink_wrap_s ? ~blink_ph_q : blink_ph_q;
        if (!scan_wrap_s || NUM_DIGITS == 1) begin
            scan_idx_d = scan_idx_q;
        end else if (scan_idx_q == IDX_W'(NUM_DIGITS - 1)) begin
            scan_idx_d = {IDX_W{1'b0}};
        end else begin
            scan_idx_d = scan_idx_q + IDX_W'(1);
        end
    end

    // Output next-state; nothing lights until a value has been latched
    always_comb begin
        seg_static_d = {NUM_DIGITS{SEG_OFF}};
        seg_mux_d    = SEG_OFF;
        digit_sel_d  = SEL_OFF;
        if (!loaded_q) begin
            seg_mux_d = SEG_OFF;
        end else if (mux_mode) begin
            seg_mux_d = polarize(digit_seg_s[scan_idx_q], AL);
            for (int k = 0; k < NUM_DIGITS; k++) begin
                digit_sel_d[k] = (scan_idx_q == IDX_W'(k)) ^ AL;
            end
        end else begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                seg_static_d[7*k +: 7] = polarize(digit_seg_s[k], AL);
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q      <= {(4*NUM_DIGITS){1'b0}};
            loaded_q     <= 1'b0;
            scan_cnt_q   <= {SCAN_W{1'b0}};
            scan_idx_q   <= {IDX_W{1'b0}};
            blink_cnt_q  <= {BLINK_W{1'b0}};
            blink_ph_q   <= 1'b0;
            seg_static_q <= {NUM_DIGITS{SEG_OFF}};
            seg_mux_q    <= SEG_OFF;
            digit_sel_q  <= SEL_OFF;
        end else begin
            value_q      <= value_d;
            loaded_q     <= loaded_d;
            scan_cnt_q   <= scan_cnt_d;
            scan_idx_q   <= scan_idx_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_ph_q   <= blink_ph_d;
            seg_static_q <= seg_static_d;
            seg_mux_q    <= seg_mux_d;
            digit_sel_q  <= digit_sel_d;
        end
    end

    assign seg_static_out = seg_static_q;
    assign seg_mux_out    = seg_mux_q;
    assign digit_sel_out  = digit_sel_q;

endmodule

// File: tb/tb_hex_display_bank.sv
// Self-checking bench for hex_display_bank (4 digits, SCAN_DIV=4, BLINK_DIV=8, active-low).
module tb_hex_display_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        latch;
    logic [15:0] value_in;
    logic        blank_lz;
    logic [3:0]  blink_en;
    logic        mux_mode;
    logic [27:0] seg_static_out;
    logic [6:0]  seg_mux_out;
    logic [3:0]  digit_sel_out;

    hex_display_bank #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (4),
        .BLINK_DIV  (8),
        .ACTIVE_LOW (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .latch          (latch),
        .value_in       (value_in),
        .blank_lz       (blank_lz),
        .blink_en       (blink_en),
        .mux_mode       (mux_mode),
        .seg_static_out (seg_static_out),
        .seg_mux_out    (seg_mux_out),
        .digit_sel_out  (digit_sel_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [27:0] st;
        logic [6:0]  mx;
        logic [3:0]  sel;
    } exp_t;

    typedef struct packed {
        logic [15:0] value;
        logic        lz;
        logic [27:0] st;
    } vec_t;

    exp_t        sb_q[$];
    vec_t        vecs[7];
    int          tests = 0;
    int          failed = 0;
    int          cnt = 0;
    logic        m_loaded = 1'b0;
    logic [15:0] m_value = 16'h0000;
    int          guard;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h3F; 4'h1: g = 7'h06; 4'h2: g = 7'h5B; 4'h3: g = 7'h4F;
            4'h4: g = 7'h66; 4'h5: g = 7'h6D; 4'h6: g = 7'h7D; 4'h7: g = 7'h07;
            4'h8: g = 7'h7F; 4'h9: g = 7'h6F; 4'hA: g = 7'h77; 4'hB: g = 7'h7C;
            4'hC: g = 7'h39; 4'hD: g = 7'h5E; 4'hE: g = 7'h79; 4'hF: g = 7'h71;
            default: g = 7'h00;
        endcase
        return g;
    endfunction

    // Expected outputs after the coming edge, from state held before it
    function automatic exp_t model(input logic r, input int c, input logic ld, input logic [15:0] v,
                                   input logic lz, input logic [3:0] be, input logic mx);
        exp_t e;
        logic [6:0] seg [4];
        logic ph;
        int idx;
        e.st = 28'hFFFFFFF;
        e.mx = 7'h7F;
        e.sel = 4'hF;
        if (!r && ld) begin
            ph = ((c / 8) % 2) == 1;
            idx = (c / 4) % 4;
            for (int d = 0; d < 4; d++) begin
                if ((be[d] && ph) || (lz && d != 0 && (v >> (4 * d)) == 16'h0000))
                    seg[d] = 7'h7F;
                else
                    seg[d] = ~glyph(v[4*d +: 4]);
            end
            if (mx) begin
                e.mx = seg[idx];
                e.sel = ~(4'b0001 << idx);
            end else begin
                e.st = {seg[3], seg[2], seg[1], seg[0]};
            end
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [27:0] act, input logic [27:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step();
        exp_t e;
        sb_q.push_back(model(rst, cnt, m_loaded, m_value, blank_lz, blink_en, mux_mode));
        if (rst) begin
            cnt = 0;
            m_loaded = 1'b0;
            m_value = 16'h0000;
        end else begin
            if (latch) begin
                m_value = value_in;
                m_loaded = 1'b1;
            end
            cnt++;
        end
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("seg_static", seg_static_out, e.st);
        check("seg_mux", {21'h0, seg_mux_out}, {21'h0, e.mx});
        check("digit_sel", {24'h0, digit_sel_out}, {24'h0, e.sel});
    endtask

    initial begin
        vecs[0] = '{16'hA5C3, 1'b0, {7'h08, 7'h12, 7'h46, 7'h30}};
        vecs[1] = '{16'h0042, 1'b1, {7'h7F, 7'h7F, 7'h19, 7'h24}};
        vecs[2] = '{16'h0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[3] = '{16'h0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[4] = '{16'h1234, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}};
        vecs[5] = '{16'h0F00, 1'b1, {7'h7F, 7'h0E, 7'h40, 7'h40}};
        vecs[6] = '{16'h8000, 1'b1, {7'h00, 7'h40, 7'h40, 7'h40}};

        // Reset overrides a held latch; outputs stay dark until the first latch
        rst = 1'b1; latch = 1'b1; value_in = 16'h1234;
        blank_lz = 1'b0; blink_en = 4'h0; mux_mode = 1'b0;
        repeat (3) step();
        check("reset_static", seg_static_out, 28'hFFFFFFF);
        rst = 1'b0; latch = 1'b0;
        repeat (3) step();
        check("post_reset_dark", seg_static_out, 28'hFFFFFFF);

        // Static decode and leading-zero blanking vectors
        for (int i = 0; i < 7; i++) begin
            blank_lz = vecs[i].lz;
            value_in = vecs[i].value;
            latch = 1'b1;
            step();
            latch = 1'b0;
            value_in = ~vecs[i].value;
            step();
            check($sformatf("vec%0d_decode", i), seg_static_out, vecs[i].st);
            step();
            check($sformatf("vec%0d_hold", i), seg_static_out, vecs[i].st);
        end

        // Blink on digit 1 from a fresh reset
        rst = 1'b1; blank_lz = 1'b0; step();
        rst = 1'b0; value_in = 16'h1234; latch = 1'b1; step();
        latch = 1'b0; blink_en = 4'b0010;
        for (int i = 0; i < 36; i++) begin
            step();
            if (cnt == 8) check("blink_lit_before", {21'h0, seg_static_out[13:7]}, {21'h0, 7'h30});
            if (cnt == 9) check("blink_first_blank", {21'h0, seg_static_out[13:7]}, {21'h0, 7'h7F});
            if (cnt == 9) check("blink_other_steady", {seg_static_out[27:14], seg_static_out[6:0]}, {7'h79, 7'h24, 7'h19});
        end

        // Mux scan over 1234
        blink_en = 4'h0; mux_mode = 1'b1;
        repeat (24) step();

        // Switch to static while scan_idx is 2
        guard = 0;
        while (((cnt / 4) % 4) != 2 && guard < 32) begin
            step();
            guard++;
        end
        check("reach_idx2", {24'h0, digit_sel_out}, {24'h0, 4'b1101});
        step();
        check("idx2_sel", {24'h0, digit_sel_out}, {24'h0, 4'b1011});
        mux_mode = 1'b0;
        step();
        check("switch_sel_off", {24'h0, digit_sel_out}, {24'h0, 4'hF});
        check("switch_static", seg_static_out, {7'h79, 7'h24, 7'h30, 7'h19});

        // Reset mid-scan restarts at digit 0
        mux_mode = 1'b1;
        repeat (6) step();
        rst = 1'b1; step();
        rst = 1'b0; latch = 1'b1; step();
        latch = 1'b0; step();
        check("rst_scan_idx0", {24'h0, digit_sel_out}, {24'h0, 4'b1110});
        check("rst_scan_seg", {21'h0, seg_mux_out}, {21'h0, 7'h19});
        repeat (8) step();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
